// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, with up to two
// pending results granted round-robin each cycle onto CDB1/CDB2.
module cdb_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int ROBEN_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FU-1:0]          FU_valid,
  input  logic [NUM_FU*ROBEN_W-1:0]  FU_ROBEN,
  input  logic [NUM_FU*DATA_W-1:0]   FU_VAL,
  output logic [NUM_FU-1:0]          FU_ready,
  input  logic                       ROB_FLUSH_Flag,
  output logic [ROBEN_W-1:0]         CDB_ROBEN1,
  output logic [DATA_W-1:0]          CDB_ROBEN1_VAL,
  output logic [ROBEN_W-1:0]         CDB_ROBEN2,
  output logic [DATA_W-1:0]          CDB_ROBEN2_VAL,
  output logic                       CDB_conflict
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SUM_W = PTR_W + 1;

  // Slot state: pend qualifies the payload registers
  logic [NUM_FU-1:0]  pend;
  logic [ROBEN_W-1:0] tag_q [NUM_FU];
  logic [DATA_W-1:0]  val_q [NUM_FU];
  logic [PTR_W-1:0]   rr_ptr;

  // Grant results and per-slot masks derived from them
  logic               g1_vld;
  logic               g2_vld;
  logic [PTR_W-1:0]   g1;
  logic [PTR_W-1:0]   g2;
  logic [PTR_W-1:0]   last_grant;
  logic [PTR_W-1:0]   rr_next;
  logic [NUM_FU-1:0]  grant_mask;
  logic [NUM_FU-1:0]  load_mask;

  // Round-robin scan from rr_ptr over registered pend bits: first hit -> g1, second -> g2
  always_comb begin : grant_scan
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    // NOTE: combinational temporaries use blocking '=' and get a default first so no latch is inferred.
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1     = '0;
    g2     = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_FU)) sum = sum - SUM_W'(NUM_FU);
      idx = sum[PTR_W-1:0];
      if (pend[idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = idx;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2     = idx;
        end
      end
    end
  end

  // Slot acceptance: a slot is free if empty or being drained this cycle; flush blocks all
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      grant_mask[i] = (g1_vld && (g1 == PTR_W'(i))) || (g2_vld && (g2 == PTR_W'(i)));
      FU_ready[i]   = !ROB_FLUSH_Flag && (!pend[i] || grant_mask[i]);
      load_mask[i]  = FU_valid[i] && FU_ready[i] &&
                      (FU_ROBEN[i*ROBEN_W +: ROBEN_W] != '0);
    end
  end

  // Next round-robin pointer: one past the last slot granted, unchanged when idle
  always_comb begin
    last_grant = g2_vld ? g2 : g1;
    rr_next    = rr_ptr;
    if (g1_vld) begin
      rr_next = (last_grant == PTR_W'(NUM_FU - 1)) ? '0 : last_grant + 1'b1;
    end
  end

  // Control state and registered CDB outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend           <= '0;
      rr_ptr         <= '0;
      CDB_ROBEN1     <= '0;
      CDB_ROBEN1_VAL <= '0;
      CDB_ROBEN2     <= '0;
      CDB_ROBEN2_VAL <= '0;
      CDB_conflict   <= 1'b0;
    end else begin
      CDB_conflict <= ($countones(pend) > 2);
      if (ROB_FLUSH_Flag) begin
        pend           <= '0;
        CDB_ROBEN1     <= '0;
        CDB_ROBEN1_VAL <= '0;
        CDB_ROBEN2     <= '0;
        CDB_ROBEN2_VAL <= '0;
      end else begin
        // A load on a slot being drained wins over its clear
        pend           <= (pend & ~grant_mask) | load_mask;
        CDB_ROBEN1     <= g1_vld ? tag_q[g1] : '0;
        CDB_ROBEN1_VAL <= g1_vld ? val_q[g1] : '0;
        CDB_ROBEN2     <= g2_vld ? tag_q[g2] : '0;
        CDB_ROBEN2_VAL <= g2_vld ? val_q[g2] : '0;
        rr_ptr         <= rr_next;
      end
    end
  end

  // Payload capture for accepted results
  // NOTE: payload storage has no reset; pend marks which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (load_mask[i]) begin
        tag_q[i] <= FU_ROBEN[i*ROBEN_W +: ROBEN_W];
        val_q[i] <= FU_VAL[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule
